// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters; request to ready takes 2 cycles plus memory wait.
// One transaction in flight: the loser holds valid until served, and an optional watchdog aborts a stalled memory.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_datain,
  input  logic                  req0_rw,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  output logic [DATA_WIDTH-1:0] req0_dataout,
  output logic                  req0_error,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_datain,
  input  logic                  req1_rw,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] req1_dataout,
  output logic                  req1_error,
  output logic [1:0]            grant,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_dataout,
  output logic                  mem_req_rw,
  output logic                  mem_req_valid,
  input  logic [DATA_WIDTH-1:0] mem_req_datain,
  input  logic                  mem_req_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [31:0] CNT_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rw;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  logic [1:0]            state;
  logic                  owner;
  logic                  rr_ptr;
  mem_req_t              req_q;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic [31:0]           cnt;

  logic any_vld;
  logic sel;
  logic watchdog_hit;
  logic resp0;
  logic resp1;

  // A lone requester wins outright; a tie goes to the round-robin pointer.
  always_comb begin
    any_vld = req0_valid | req1_valid;
    sel     = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
  end

  assign watchdog_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
      req_q  <= '0;
      rdata  <= '0;
      err    <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_vld) begin
            owner <= sel;
            req_q <= sel ? {req1_addr, req1_rw, req1_datain}
                         : {req0_addr, req0_rw, req0_datain};
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Memory completion takes precedence over a simultaneous watchdog expiry.
          if (mem_req_ready) begin
            rdata <= req_q.rw ? '0 : mem_req_datain;
            err   <= 1'b0;
            state <= RESP;
          end else if (watchdog_hit) begin
            rdata <= '0;
            err   <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RESP: begin
          rr_ptr <= ~owner;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req_valid   = (state == BUSY);
  assign mem_req_addr    = req_q.addr;
  assign mem_req_rw      = req_q.rw;
  assign mem_req_dataout = req_q.wdata;

  assign grant = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

  assign resp0 = (state == RESP) && !owner;
  assign resp1 = (state == RESP) && owner;

  assign req0_ready   = resp0;
  assign req0_dataout = resp0 ? rdata : '0;
  assign req0_error   = resp0 & err;
  assign req1_ready   = resp1;
  assign req1_dataout = resp1 ? rdata : '0;
  assign req1_error   = resp1 & err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed then randomized bench for mem_port_arbiter against a transaction-level round-robin model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [31:0]  req0_addr, req1_addr;
  logic [127:0] req0_datain, req1_datain;
  logic         req0_rw, req1_rw, req0_valid, req1_valid;
  logic         req0_ready, req1_ready, req0_error, req1_error;
  logic [127:0] req0_dataout, req1_dataout;
  logic [1:0]   grant;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_dataout, mem_req_datain;
  logic         mem_req_rw, mem_req_valid, mem_req_ready;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: pending requests per requester and the preferred requester.
  logic         pend [2];
  logic [31:0]  m_addr [2];
  logic [127:0] m_data [2];
  logic         m_rw [2];
  int           pref;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(128), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_addr(req0_addr), .req0_datain(req0_datain), .req0_rw(req0_rw), .req0_valid(req0_valid),
    .req0_ready(req0_ready), .req0_dataout(req0_dataout), .req0_error(req0_error),
    .req1_addr(req1_addr), .req1_datain(req1_datain), .req1_rw(req1_rw), .req1_valid(req1_valid),
    .req1_ready(req1_ready), .req1_dataout(req1_dataout), .req1_error(req1_error),
    .grant(grant), .mem_req_addr(mem_req_addr), .mem_req_dataout(mem_req_dataout),
    .mem_req_rw(mem_req_rw), .mem_req_valid(mem_req_valid),
    .mem_req_datain(mem_req_datain), .mem_req_ready(mem_req_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    req0_valid = pend[0]; req0_addr = m_addr[0]; req0_datain = m_data[0]; req0_rw = m_rw[0];
    req1_valid = pend[1]; req1_addr = m_addr[1]; req1_datain = m_data[1]; req1_rw = m_rw[1];
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [127:0] d, input logic w);
    pend[r] = 1'b1; m_addr[r] = a; m_data[r] = d; m_rw[r] = w;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, grant, 2'b00);
    chk({tag, "_mvld"}, mem_req_valid, 1'b0);
    chk({tag, "_rdy"}, {req0_ready, req1_ready}, 2'b00);
    chk({tag, "_err"}, {req0_error, req1_error}, 2'b00);
    chk({tag, "_dout0"}, req0_dataout, 128'd0);
    chk({tag, "_dout1"}, req1_dataout, 128'd0);
  endtask

  // Called at a falling edge while the DUT is idle; the next rising edge starts arbitration.
  task automatic serve(input int w, input logic [127:0] md, input bit scramble);
    int o, blen;
    logic e;
    logic [127:0] exp_d;
    drive_inputs();
    o     = (pend[0] && pend[1]) ? pref : (pend[0] ? 0 : 1);
    e     = (w >= TO);
    blen  = e ? TO : w + 1;
    exp_d = (m_rw[o] || e) ? 128'd0 : md;
    for (int i = 0; i < blen; i++) begin
      @(negedge clock);
      chk("busy_mvld", mem_req_valid, 1'b1);
      chk("busy_grant", grant, (o == 0) ? 2'b01 : 2'b10);
      chk("busy_addr", mem_req_addr, m_addr[o]);
      chk("busy_rw", mem_req_rw, m_rw[o]);
      chk("busy_wdata", mem_req_dataout, m_data[o]);
      chk("busy_rdy", {req0_ready, req1_ready}, 2'b00);
      mem_req_ready  = (i == w);
      mem_req_datain = (i == w) ? md : {$urandom, $urandom, $urandom, $urandom};
      if (scramble && i == 0) begin
        if (o == 0) begin
          req0_addr = ~m_addr[0]; req0_datain = ~m_data[0]; req0_rw = ~m_rw[0];
          req0_valid = 1'($urandom_range(1, 0));
        end else begin
          req1_addr = ~m_addr[1]; req1_datain = ~m_data[1]; req1_rw = ~m_rw[1];
          req1_valid = 1'($urandom_range(1, 0));
        end
      end
    end
    @(negedge clock);
    chk("resp_mvld", mem_req_valid, 1'b0);
    chk("resp_grant", grant, (o == 0) ? 2'b01 : 2'b10);
    chk("resp_rdy", (o == 0) ? req0_ready : req1_ready, 1'b1);
    chk("resp_data", (o == 0) ? req0_dataout : req1_dataout, exp_d);
    chk("resp_err", (o == 0) ? req0_error : req1_error, e);
    chk("resp_other_rdy", (o == 0) ? req1_ready : req0_ready, 1'b0);
    chk("resp_other_data", (o == 0) ? req1_dataout : req0_dataout, 128'd0);
    chk("resp_other_err", (o == 0) ? req1_error : req0_error, 1'b0);
    mem_req_ready = 1'b0;
    pend[o] = 1'b0;
    pref = 1 - o;
    drive_inputs();
    @(negedge clock);
    chk_idle("idle");
  endtask

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int r = 0; r < 2; r++) begin m_addr[r] = '0; m_data[r] = '0; m_rw[r] = 1'b0; end
    pref = 0;
    mem_req_ready = 1'b0;
    mem_req_datain = '0;
    reset_n = 1'b0;

    // Reset held with a pending write: nothing may leak out.
    set_req(0, 32'hAB00, 128'h1122, 1'b1);
    drive_inputs();
    repeat (3) @(negedge clock);
    chk_idle("rst");
    chk("rst_maddr", mem_req_addr, 32'd0);
    chk("rst_mdout", mem_req_dataout, 128'd0);
    chk("rst_mrw", mem_req_rw, 1'b0);
    reset_n = 1'b1;
    serve(0, 128'h0, 1'b0);

    // Read from req1 with two memory wait cycles.
    set_req(1, 32'hBB00, 128'h0, 1'b0);
    serve(2, 128'h3344, 1'b0);

    // Simultaneous requests alternate 01, 10, 01.
    set_req(0, 32'hEB00, 128'h55, 1'b0);
    set_req(1, 32'hBB00, 128'h66, 1'b0);
    serve(0, 128'hA1, 1'b0);
    set_req(0, 32'hEB10, 128'h77, 1'b1);
    serve(1, 128'hA2, 1'b0);
    serve(0, 128'hA3, 1'b0);

    // Watchdog abort, then a normal transaction.
    set_req(0, 32'hC000, 128'h0, 1'b0);
    serve(TO + 5, 128'hDEAD, 1'b0);
    set_req(1, 32'hC100, 128'h0, 1'b0);
    serve(1, 128'hBEEF, 1'b0);
    set_req(0, 32'hC200, 128'h0, 1'b0);
    serve(0, 128'h1234, 1'b0);

    // Reset during BUSY of req1; afterwards req0 wins from the reset pointer.
    set_req(0, 32'hD000, 128'h0, 1'b0);
    set_req(1, 32'hD100, 128'h0, 1'b0);
    drive_inputs();
    @(negedge clock);
    chk("mid_grant", grant, 2'b10);
    chk("mid_mvld", mem_req_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_mvld", mem_req_valid, 1'b0);
    chk("mid_rst_grant", grant, 2'b00);
    repeat (2) begin
      @(negedge clock);
      chk("mid_rst_rdy", {req0_ready, req1_ready}, 2'b00);
    end
    reset_n = 1'b1;
    pref = 0;
    serve(0, 128'h5150, 1'b0);
    serve(0, 128'h5151, 1'b0);

    // Randomized traffic with random memory waits, including expiries.
    for (int n = 0; n < 150; n++) begin
      if (!pend[0] && !pend[1] && $urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(3, 1)) begin
          @(negedge clock);
          chk_idle("gap");
        end
      end
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(1, 0) == 1)
          set_req(r, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1, 0)));
      if (!pend[0] && !pend[1])
        set_req(int'($urandom_range(1, 0)), $urandom, {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(1, 0)));
      serve(int'($urandom_range(6, 0)), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
